// File: rtl/d_flipflop_pkg.sv
// Shared constants and types for the d_flipflop storage primitive.
package d_flipflop_pkg;

    localparam int DFF_MAX_WIDTH  = 64;
    localparam int DFF_MAX_STAGES = 4;

    typedef logic [DFF_MAX_WIDTH-1:0] dff_data_t;

    localparam dff_data_t DFF_RESET_DEFAULT = '0;

endpackage

// File: rtl/d_flipflop_dff_cell.sv
// Single WIDTH-bit register stage with asynchronous active-low reset to RESET_VALUE.
module dff_cell
    import d_flipflop_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = DFF_RESET_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_flipflop.sv
// Parameterizable D register chain (STAGES deep, WIDTH wide) with async active-low reset.
// Optional change detector on q enabled by defining D_FLIPFLOP_CHANGE_EN.
module d_flipflop
    import d_flipflop_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = DFF_RESET_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef D_FLIPFLOP_CHANGE_EN
    ,
    output logic             changed
`endif
);

    if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_bad_width
        $error("d_flipflop: WIDTH %0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
    end
    if (STAGES < 1 || STAGES > DFF_MAX_STAGES) begin : g_bad_stages
        $error("d_flipflop: STAGES %0d outside 1..%0d", STAGES, DFF_MAX_STAGES);
    end

    // data_p[0] is the raw input; data_p[k] is the output of stage k-1.
    logic [STAGES:0][WIDTH-1:0] data_p;

    assign data_p[0] = d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        dff_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst),
            .d     (data_p[i]),
            .q     (data_p[i+1])
        );
    end

    assign q = data_p[STAGES];

`ifdef D_FLIPFLOP_CHANGE_EN
    // armed suppresses a pulse on the first loaded edge after reset release.
    logic armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed   <= 1'b0;
            changed <= 1'b0;
        end else begin
            armed   <= 1'b1;
            changed <= armed && (data_p[STAGES-1] != q);
        end
    end
`endif

endmodule

// File: tb/tb_d_flipflop.sv
// Scoreboard bench for d_flipflop: a default instance and an 8-bit, 3-stage, reset-to-3C instance.
module tb_d_flipflop;

    logic       clk;
    logic       rst;
    logic       d_def;
    logic [7:0] d_pipe;
    logic       q_def;
    logic [7:0] q_pipe;
    logic       ch_def;
    logic       ch_pipe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       q_def;
        logic [7:0] q_pipe;
        logic       ch_def;
        logic       ch_pipe;
    } exp_t;

    exp_t       sb[$];
    logic       hist_def[$];
    logic [7:0] hist_pipe[$];
    logic       prev_def;
    logic [7:0] prev_pipe;

    localparam logic [7:0] PIPE_RV = 8'h3C;

    d_flipflop u_dut_def (
        .clk     (clk),
        .rst     (rst),
        .d       (d_def),
        .q       (q_def)
`ifdef D_FLIPFLOP_CHANGE_EN
        ,
        .changed (ch_def)
`endif
    );

    d_flipflop #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (PIPE_RV)
    ) u_dut_pipe (
        .clk     (clk),
        .rst     (rst),
        .d       (d_pipe),
        .q       (q_pipe)
`ifdef D_FLIPFLOP_CHANGE_EN
        ,
        .changed (ch_pipe)
`endif
    );

`ifndef D_FLIPFLOP_CHANGE_EN
    assign ch_def  = 1'b0;
    assign ch_pipe = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: q is the d sampled STAGES loaded edges ago, else the reset value.
    always @(posedge clk) begin
        exp_t e;
        int   n;
        if (!rst) begin
            hist_def.delete();
            hist_pipe.delete();
            e = '{q_def: 1'b0, q_pipe: PIPE_RV, ch_def: 1'b0, ch_pipe: 1'b0};
        end else begin
            hist_def.push_back(d_def);
            hist_pipe.push_back(d_pipe);
            n = hist_pipe.size();
            e.q_def   = hist_def[n-1];
            e.q_pipe  = (n >= 3) ? hist_pipe[n-3] : PIPE_RV;
            e.ch_def  = (n >= 2) && (e.q_def != prev_def);
            e.ch_pipe = (n >= 2) && (e.q_pipe != prev_pipe);
        end
        prev_def  = e.q_def;
        prev_pipe = e.q_pipe;
        sb.push_back(e);
    end

    // Asynchronous reset overrides whatever the last edge promised.
    always @(negedge rst) begin
        hist_def.delete();
        hist_pipe.delete();
        if (sb.size() > 0) begin
            sb[sb.size()-1] = '{q_def: 1'b0, q_pipe: PIPE_RV, ch_def: 1'b0, ch_pipe: 1'b0};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q_def", 64'(q_def), 64'(e.q_def));
            check("q_pipe", 64'(q_pipe), 64'(e.q_pipe));
`ifdef D_FLIPFLOP_CHANGE_EN
            check("changed_def", 64'(ch_def), 64'(e.ch_def));
            check("changed_pipe", 64'(ch_pipe), 64'(e.ch_pipe));
`endif
        end
    end

    task automatic drive(input logic a, input logic [7:0] b);
        d_def  = a;
        d_pipe = b;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        d_def  = 1'b0;
        d_pipe = 8'h00;
        #1 rst = 1'b0;
        #1;
        check("por_q_def", 64'(q_def), 64'(1'b0));
        check("por_q_pipe", 64'(q_pipe), 64'(PIPE_RV));
`ifdef D_FLIPFLOP_CHANGE_EN
        check("por_changed_def", 64'(ch_def), 64'(1'b0));
`endif
        // Power-up reset for 20 ns with random data on d.
        @(posedge clk);
        #2;
        repeat (2) drive(1'($urandom), 8'($urandom));
        rst = 1'b1;

        // Capture, change-flag sequence 1,1,0 and single-cycle A5 through the pipe.
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        repeat (4) drive(1'b0, 8'h00);

        repeat (40) drive(1'($urandom), 8'($urandom));

        // Async reset 3 ns after an edge while q_def is 1.
        repeat (3) drive(1'b1, 8'hFF);
        #1 rst = 1'b0;
        #1;
        check("async_q_def", 64'(q_def), 64'(1'b0));
        check("async_q_pipe", 64'(q_pipe), 64'(PIPE_RV));
`ifdef D_FLIPFLOP_CHANGE_EN
        check("async_changed_pipe", 64'(ch_pipe), 64'(1'b0));
`endif
        repeat (3) drive(1'($urandom), 8'($urandom));
        rst = 1'b1;

        // Release into zeros: pipe leaves 3C after exactly three edges.
        repeat (5) drive(1'b0, 8'h00);
        drive(1'b1, 8'h5A);

        // Random data with occasional reset cycles.
        repeat (80) begin
            rst = ($urandom_range(0, 15) != 0);
            drive(1'($urandom), 8'($urandom));
        end
        rst = 1'b1;
        repeat (6) drive(1'($urandom), 8'($urandom));

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_flipflop.md
# d_flipflop

Parameterizable positive-edge D-type register with asynchronous active-low reset. It is the base storage primitive of the verification sandbox, and the unit that the `inter` interface and the `test` program drive. With default parameters it is a single-bit, single-stage D flip-flop. Optional parameters widen the data path and add a register pipeline chain for synchronizer use.

## Interface
Parameters:
- `WIDTH`, default 1: data width in bits; legal range 1..64.
- `STAGES`, default 1: number of cascaded register stages from `d` to `q`; legal range 1..4.
- `RESET_VALUE`, default all-zero: value loaded into every stage during reset; sized to `WIDTH`.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  reset; one clock, reset is asynchronous and active-low (`rst`=0 resets).
- `d`  input  `WIDTH`  data input, sampled on each rising `clk` edge.
- `q`  output  `WIDTH`  registered output, driven directly from the last stage.
- `changed`  output  1  present only with `D_FLIPFLOP_CHANGE_EN`; see Configuration.

## Operation
- Stage 0 captures `d` on each rising `clk` edge.
- Stage k captures stage k-1 on the same edge.
- `q` equals the last stage; there is no combinational path from `d` to `q`.
- No enable: every rising edge loads a new value.
- Reset: when `rst` falls, all stages and `q` take `RESET_VALUE` immediately, without waiting for `clk`.
- While `rst`=0, edges of `clk` are ignored and the outputs hold `RESET_VALUE`.
- Reset release: `rst` rising has no effect by itself. The first rising `clk` edge with `rst`=1 loads `d` into stage 0.
- Reset mid-pipeline: data in flight is discarded and not replayed.
- X/Z on `d` propagates unchanged; no filtering.

## Timing
- Latency from `d` to `q`: `STAGES` rising edges. The default is 1 cycle: `d` sampled at edge n appears on `q` after edge n.
- Throughput: one new sample per cycle.
- Reset assertion to `q`=`RESET_VALUE`: asynchronous, no clock required.
- Reset deassertion to first valid `q`: `STAGES` rising edges.
- Setup/hold: `d` must be stable around the rising edge. `rst` deassertion must meet recovery/removal relative to `clk`; the bench changes stimulus away from the rising edge.
- Rising edge with `rst` changing in the same delta: treated as still in reset; the stage loads `RESET_VALUE`.

## Configuration
- Macro `D_FLIPFLOP_CHANGE_EN`.
- With the macro defined:
  - Output `changed` is present.
  - `changed` is registered and pulses 1 for exactly one cycle after any edge on which `q` took a value different from its previous value.
  - `changed` resets to 0 and stays 0 during reset.
  - No pulse on the reset-release transition itself; the first comparison is made after the first loaded edge.
- Without the macro: no `changed` port, no comparison logic, no extra register.

## Structure
- Package `d_flipflop_pkg`:
  - constants `DFF_MAX_WIDTH` = 64 and `DFF_MAX_STAGES` = 4;
  - typedef `dff_data_t` (logic vector of `DFF_MAX_WIDTH`);
  - default reset constant `DFF_RESET_DEFAULT` = '0.
- Sub-module `dff_cell`:
  - one `WIDTH`-bit register stage with async active-low reset to `RESET_VALUE`;
  - instantiated `STAGES` times in a generate loop.
- The top contains parameter range checks (elaboration error when out of range) and, under the macro, the change detector.

## Test plan
- Reset at power-up: `rst`=0 for 20 ns with the 10 ns `clk` toggling and `d` random -> `q`=0 throughout. `q` becomes 0 as soon as `rst`=0, before any edge.
- Basic capture, defaults: release reset, drive `d`=1 between edges -> `q`=1 after the next rising edge. Then `d`=0 -> `q`=0 one edge later.
- Async reset mid-cycle: with `q`=1, drop `rst` 3 ns after a rising edge -> `q`=0 at that instant. `q` stays 0 on subsequent edges until `rst`=1, then follows `d` from the first edge after release.
- Pipeline: with `WIDTH`=8 and `STAGES`=3, drive `d`=8'hA5 for one cycle -> `q`=8'hA5 exactly 3 edges later, for one cycle.
- Reset value: with `RESET_VALUE`=8'h3C, assert reset -> `q`=8'h3C. Release with `d`=8'h00 -> `q`=8'h00 after `STAGES` edges.
- Change flag, with `D_FLIPFLOP_CHANGE_EN`: `d` sequence 1,1,0 -> `changed` pulses once after the 1->0 transition, and is 0 during reset and on the repeated 1.
